// File: rtl/lsu_store_buffer.sv
// In-order store buffer between the LSU and a single-port backing memory.
// Posts stores, drains them when the port is idle, and forwards them to loads.
module lsu_store_buffer #(
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_ren,
    input  logic [63:0]         mem_raddr,
    output logic                mem_rvalid,
    output logic [63:0]         mem_rdata,
    input  logic                mem_wen,
    input  logic [63:0]         mem_waddr,
    input  logic [63:0]         mem_wdata,
    input  logic                bk_ready,
    output logic                bk_ren,
    output logic [63:0]         bk_raddr,
    input  logic                bk_rvalid,
    input  logic [63:0]         bk_rdata,
    output logic                bk_wen,
    output logic [63:0]         bk_waddr,
    output logic [63:0]         bk_wdata,
    output logic                rd_busy,
    output logic                sb_full,
    output logic [CNT_BITS-1:0] sb_count,
    output logic                err_overflow,
    output logic                err_rd_busy
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RESP
    } state_t;

    state_t state, state_d;

    logic [63:0]         sb_addr [DEPTH];
    logic [63:0]         sb_data [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [CNT_BITS-1:0] count;
    logic [63:0]         raddr_q, raddr_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                ovf_q, rdb_q;
    logic                drain_ok, push, pop;
    logic                fwd_hit;
    logic [63:0]         fwd_data;

    assign drain_ok = (state == IDLE) && (count != '0) && !mem_ren;
    assign pop      = drain_ok && bk_ready;
    assign push     = mem_wen && ((count < CNT_BITS'(DEPTH)) || pop);

    // Oldest to youngest so the last match wins; the incoming store is youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_BITS'(i) < count) &&
                (sb_addr[head + PW'(i)] == mem_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head + PW'(i)];
            end
        end
        if (push && (mem_waddr == mem_raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem_wdata;
        end
    end

    always_comb begin
        state_d    = state;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        bk_ren     = 1'b0;
        mem_rvalid = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_ren) begin
                    if (fwd_hit) begin
                        rdata_d = fwd_data;
                        state_d = RESP;
                    end else begin
                        raddr_d = mem_raddr;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                bk_ren = 1'b1;
                if (bk_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bk_rvalid) begin
                    rdata_d = bk_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                mem_rvalid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            raddr_q <= '0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
            rdb_q   <= 1'b0;
        end else begin
            state   <= state_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            unique case (1'b1)
                (push && !pop): count <= count + 1'b1;
                (pop && !push): count <= count - 1'b1;
                default: ;
            endcase
            if (mem_wen && !push) ovf_q <= 1'b1;
            if (mem_ren && rd_busy) rdb_q <= 1'b1;
        end
    end

    // Payload needs no reset: every read of it is qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= mem_waddr;
            sb_data[tail] <= mem_wdata;
        end
    end

    assign bk_wen       = drain_ok;
    assign bk_waddr     = drain_ok ? sb_addr[head] : '0;
    assign bk_wdata     = drain_ok ? sb_data[head] : '0;
    assign bk_raddr     = (state == RD_REQ) ? raddr_q : '0;
    assign mem_rdata    = mem_rvalid ? rdata_q : '0;
    assign rd_busy      = (state != IDLE);
    assign sb_full      = (count == CNT_BITS'(DEPTH));
    assign sb_count     = count;
    assign err_overflow = ovf_q;
    assign err_rd_busy  = rdb_q;

endmodule
